vga_timing_counter: RTL and testbench

VGA_TIMING_COUNTER -- requirements
Module: vga_timing_counter

---
 rtl/vga_timing_counter.sv | 80 ++++++++
 tb/tb_vga_timing_counter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_counter.sv
// vga_timing_counter: free-running horizontal/vertical raster counters with
// zero-latency decodes of the visible window.
//
// Ports:
//   clk          single system clock, all state on the rising edge
//   reset        asynchronous, active-high; clears both counters
//   enable       counting enable; low freezes the counters
//   H_counter    horizontal clock count, 0..H_TOTAL-1
//   V_counter    line count, 0..V_TOTAL-1
//   line_end     high while H_counter is on the last clock of a line
//   frame_end    high while on the last clock of the last line
//   pixel_tick   one-clock strobe at the start of each visible pixel (gated by enable)
//   pixel_x      visible column, 0 outside the window
//   pixel_y      visible row, 0 outside the window
//   in_display   high when both counters are inside the visible window
module vga_timing_counter #(
    parameter int unsigned H_TOTAL      = 3200,
    parameter int unsigned V_TOTAL      = 521,
    parameter int unsigned H_DISP_START = 575,
    parameter int unsigned H_DISP_END   = 3134,
    parameter int unsigned V_DISP_START = 31,
    parameter int unsigned V_DISP_END   = 510
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [11:0] H_counter,
    output logic [9:0]  V_counter,
    output logic        line_end,
    output logic        frame_end,
    output logic        pixel_tick,
    output logic [9:0]  pixel_x,
    output logic [8:0]  pixel_y,
    output logic        in_display
);

    logic        h_wrap;
    logic        v_wrap;
    logic        h_vis;
    logic        v_vis;
    logic [11:0] h_off;

    // Wrap tests use >= so an out-of-range value recovers on the next enabled edge.
    assign h_wrap = (H_counter >= 12'(H_TOTAL - 1));
    assign v_wrap = (V_counter >= 10'(V_TOTAL - 1));

    // Raster counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            H_counter <= 12'd0;
            V_counter <= 10'd0;
        end else if (enable) begin
            if (h_wrap) begin
                H_counter <= 12'd0;
                if (v_wrap) begin
                    V_counter <= 10'd0;
                end else begin
                    V_counter <= V_counter + 10'd1;
                end
            end else begin
                H_counter <= H_counter + 12'd1;
            end
        end
    end

    // Window and position decodes, combinational from the counter registers.
    assign h_vis = (H_counter >= 12'(H_DISP_START)) && (H_counter <= 12'(H_DISP_END));
    assign v_vis = (V_counter >= 10'(V_DISP_START)) && (V_counter <= 10'(V_DISP_END));
    assign h_off = H_counter - 12'(H_DISP_START);

    assign line_end   = (H_counter == 12'(H_TOTAL - 1));
    assign frame_end  = line_end && (V_counter == 10'(V_TOTAL - 1));
    assign in_display = h_vis && v_vis;

    // Each pixel spans four clocks; strobe on the first of the four.
    assign pixel_tick = in_display && enable && (h_off[1:0] == 2'b00);
    assign pixel_x    = in_display ? h_off[11:2] : 10'd0;
    assign pixel_y    = in_display ? 9'(V_counter - 10'(V_DISP_START)) : 9'd0;

endmodule

// File: tb/tb_vga_timing_counter.sv
// Testbench for vga_timing_counter: two instances share stimulus, one with
// default parameters and one with a short frame (8 lines) so full-frame
// behaviour fits in a short run. Both are compared each cycle against a
// position-based reference model (edge count -> raster position).
module tb_vga_timing_counter;

    localparam int HT  = 3200;
    localparam int HS  = 575;
    localparam int HE  = 3134;
    localparam int VTA = 521;
    localparam int VSA = 31;
    localparam int VEA = 510;
    localparam int VTB = 8;
    localparam int VSB = 2;
    localparam int VEB = 5;

    logic clk = 1'b0;
    logic reset;
    logic enable;

    logic [11:0] h_a, h_b;
    logic [9:0]  v_a, v_b;
    logic        le_a, le_b, fe_a, fe_b, pt_a, pt_b, id_a, id_b;
    logic [9:0]  px_a, px_b;
    logic [8:0]  py_a, py_b;
    logic [44:0] oa, ob;

    int checks   = 0;
    int failures = 0;
    int n        = 0;   // enabled edges since last reset

    always #5 clk = ~clk;

    vga_timing_counter dut_a (
        .clk(clk), .reset(reset), .enable(enable),
        .H_counter(h_a), .V_counter(v_a), .line_end(le_a), .frame_end(fe_a),
        .pixel_tick(pt_a), .pixel_x(px_a), .pixel_y(py_a), .in_display(id_a)
    );

    vga_timing_counter #(
        .V_TOTAL(VTB), .V_DISP_START(VSB), .V_DISP_END(VEB)
    ) dut_b (
        .clk(clk), .reset(reset), .enable(enable),
        .H_counter(h_b), .V_counter(v_b), .line_end(le_b), .frame_end(fe_b),
        .pixel_tick(pt_b), .pixel_x(px_b), .pixel_y(py_b), .in_display(id_b)
    );

    assign oa = {h_a, v_a, le_a, fe_a, pt_a, px_a, py_a, id_a};
    assign ob = {h_b, v_b, le_b, fe_b, pt_b, px_b, py_b, id_b};

    // Expected outputs from the raster position reached after n enabled edges.
    function automatic logic [44:0] model(input int cnt, input logic en,
                                          input int vt, input int vs, input int ve);
        int h;
        int v;
        logic ind, le, fe, pt;
        logic [9:0] px;
        logic [8:0] py;
        h   = cnt % HT;
        v   = (cnt / HT) % vt;
        ind = (h >= HS) && (h <= HE) && (v >= vs) && (v <= ve);
        le  = (h == HT - 1);
        fe  = le && (v == vt - 1);
        pt  = ind && en && (((h - HS) % 4) == 0);
        px  = ind ? 10'((h - HS) / 4) : 10'd0;
        py  = ind ? 9'(v - vs) : 9'd0;
        return {12'(h), 10'(v), le, fe, pt, px, py, ind};
    endfunction

    // Advance one clock with the given enable, then settle past the edge.
    task automatic cycle(input logic en);
        enable = en;
        @(posedge clk);
        if (en) n++;
        #1;
    endtask

    task automatic test_reset();
        logic [44:0] ea, eb;
        reset  = 1'b1;
        enable = 1'b1;
        n      = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            ea = model(0, enable, VTA, VSA, VEA);
            eb = model(0, enable, VTB, VSB, VEB);
            checks++;
            if (oa !== ea) begin failures++; $display("FAIL reset_a got=%h exp=%h", oa, ea); end
            checks++;
            if (ob !== eb) begin failures++; $display("FAIL reset_b got=%h exp=%h", ob, eb); end
        end
        reset = 1'b0;
        #1;
        checks++;
        if (oa !== model(0, enable, VTA, VSA, VEA)) begin
            failures++; $display("FAIL post_reset got=%h exp=%h", oa, model(0, enable, VTA, VSA, VEA));
        end
    endtask

    task automatic test_first_line();
        int le_count = 0;
        logic [44:0] ea;
        for (int i = 0; i < HT; i++) begin
            cycle(1'b1);
            ea = model(n, 1'b1, VTA, VSA, VEA);
            if (le_a) le_count++;
            checks++;
            if (oa !== ea) begin failures++; $display("FAIL first_line n=%0d got=%h exp=%h", n, oa, ea); end
        end
        checks++;
        if (h_a !== 12'd0 || v_a !== 10'd1) begin
            failures++; $display("FAIL line_wrap got=(%0d,%0d) exp=(0,1)", h_a, v_a);
        end
        checks++;
        if (le_count != 1) begin failures++; $display("FAIL line_end_count got=%0d exp=1", le_count); end
    endtask

    task automatic test_frame();
        int fe_b_count = 0;
        int fe_a_count = 0;
        int tick_b     = 0;
        int tick_line2 = 0;
        logic [44:0] ea, eb;
        // dut_b frame is HT*VTB edges; also includes the first line already run
        while (n < HT * VTB) begin
            if (pt_b) begin
                tick_b++;
                if (v_b == 10'(VSB)) tick_line2++;
            end
            cycle(1'b1);
            if (fe_b) fe_b_count++;
            if (fe_a) fe_a_count++;
            ea = model(n, 1'b1, VTA, VSA, VEA);
            eb = model(n, 1'b1, VTB, VSB, VEB);
            checks++;
            if (oa !== ea) begin failures++; $display("FAIL frame_a n=%0d got=%h exp=%h", n, oa, ea); end
            checks++;
            if (ob !== eb) begin failures++; $display("FAIL frame_b n=%0d got=%h exp=%h", n, ob, eb); end
        end
        checks++;
        if (h_b !== 12'd0 || v_b !== 10'd0) begin
            failures++; $display("FAIL frame_wrap got=(%0d,%0d) exp=(0,0)", h_b, v_b);
        end
        checks++;
        if (fe_b_count != 1) begin failures++; $display("FAIL frame_end_count got=%0d exp=1", fe_b_count); end
        checks++;
        if (fe_a_count != 0) begin failures++; $display("FAIL frame_end_a got=%0d exp=0", fe_a_count); end
        checks++;
        if (tick_line2 != 640) begin failures++; $display("FAIL ticks_first_line got=%0d exp=640", tick_line2); end
        checks++;
        if (tick_b != 640 * (VEB - VSB + 1)) begin
            failures++; $display("FAIL ticks_frame got=%0d exp=%0d", tick_b, 640 * (VEB - VSB + 1));
        end
    endtask

    task automatic test_enable_hold();
        logic [44:0] ea, eb;
        // park on visible line VSB of dut_b at H=1000
        while ((n % (HT * VTB)) != HT * VSB + 1000) cycle(1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0);
            ea = model(n, 1'b0, VTA, VSA, VEA);
            eb = model(n, 1'b0, VTB, VSB, VEB);
            checks++;
            if (oa !== ea) begin failures++; $display("FAIL hold_a got=%h exp=%h", oa, ea); end
            checks++;
            if (ob !== eb || h_b !== 12'd1000 || pt_b !== 1'b0) begin
                failures++; $display("FAIL hold_b got=%h exp=%h", ob, eb);
            end
        end
        cycle(1'b1);
        checks++;
        if (h_b !== 12'd1001 || h_a !== 12'd1001) begin
            failures++; $display("FAIL resume got=%0d/%0d exp=1001", h_a, h_b);
        end
    endtask

    task automatic test_random();
        logic en;
        logic [44:0] ea, eb;
        for (int i = 0; i < 4000; i++) begin
            en = ($urandom_range(0, 3) != 0);
            cycle(en);
            ea = model(n, en, VTA, VSA, VEA);
            eb = model(n, en, VTB, VSB, VEB);
            checks++;
            if (oa !== ea) begin failures++; $display("FAIL random_a n=%0d got=%h exp=%h", n, oa, ea); end
            checks++;
            if (ob !== eb) begin failures++; $display("FAIL random_b n=%0d got=%h exp=%h", n, ob, eb); end
        end
    endtask

    task automatic test_async_reset();
        logic [44:0] ea, eb;
        while ((n % HT) != 2000) cycle(1'b1);
        #2;
        reset = 1'b1;
        #1;
        n = 0;
        checks++;
        if (h_a !== 12'd0 || v_a !== 10'd0 || h_b !== 12'd0 || v_b !== 10'd0) begin
            failures++; $display("FAIL async_reset got=(%0d,%0d) exp=(0,0)", h_a, v_a);
        end
        cycle(1'b1);
        n = 0;
        checks++;
        if (ob !== model(0, 1'b1, VTB, VSB, VEB)) begin
            failures++; $display("FAIL reset_held got=%h exp=%h", ob, model(0, 1'b1, VTB, VSB, VEB));
        end
        reset = 1'b0;
        cycle(1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1);
            ea = model(n, 1'b1, VTA, VSA, VEA);
            eb = model(n, 1'b1, VTB, VSB, VEB);
            checks++;
            if (oa !== ea) begin failures++; $display("FAIL restart_a n=%0d got=%h exp=%h", n, oa, ea); end
            checks++;
            if (ob !== eb) begin failures++; $display("FAIL restart_b n=%0d got=%h exp=%h", n, ob, eb); end
        end
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        test_reset();
        test_first_line();
        test_frame();
        test_enable_hold();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
